// File: rtl/branch_pht.sv
// Two-bit saturating-counter PHT with registered fetch-side prediction and EX-side training.
// Optional gshare indexing under `BHT_GSHARE_EN`; a reset-time sweep initialises every counter to weak-NT.
module branch_pht #(
    parameter int PHT_IDX_W = 10,
    parameter int GHR_W     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcF,
    input  logic        stallD,
    input  logic        flushD,
    output logic        pred_takeD,
    input  logic        branchE,
    input  logic        stallE,
    input  logic [31:0] pcE,
    input  logic        pred_takeE,
    input  logic        actual_takeE,
    output logic        mispredictE,
    output logic        init_busy
);

    localparam int DEPTH = 1 << PHT_IDX_W;

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t               state_q;
    logic [PHT_IDX_W-1:0] sweep_idx_q;
    logic [PHT_IDX_W-1:0] sweep_idx_d;
    logic                 init_busy_q;
    logic                 pred_take_q;
    logic                 pred_take_d;
    logic [1:0]           pht_q [DEPTH];

    logic [PHT_IDX_W-1:0] ghr_ext;
    logic [PHT_IDX_W-1:0] lk_idx;
    logic [PHT_IDX_W-1:0] up_idx;
    logic                 train;
    logic [1:0]           cnt_old;
    logic [1:0]           cnt_new;
    logic [1:0]           lk_cnt;

    assign train = (state_q == ST_READY) & branchE & ~stallE;

`ifdef BHT_GSHARE_EN
    logic [GHR_W-1:0] ghr_q;
    logic [GHR_W-1:0] ghr_d;

    always_comb begin
        ghr_d = ghr_q;
        if (train) begin
            ghr_d = GHR_W'({ghr_q, actual_takeE});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    assign ghr_ext = PHT_IDX_W'(ghr_q);
`else
    assign ghr_ext = '0;
`endif

    assign lk_idx  = pcF[PHT_IDX_W+1:2] ^ ghr_ext;
    assign up_idx  = pcE[PHT_IDX_W+1:2] ^ ghr_ext;
    assign cnt_old = pht_q[up_idx];

    always_comb begin
        cnt_new = cnt_old;
        if (actual_takeE) begin
            if (cnt_old != 2'b11) cnt_new = cnt_old + 2'b01;
        end else begin
            if (cnt_old != 2'b00) cnt_new = cnt_old - 2'b01;
        end
    end

    // Write-first: a same-cycle update to the looked-up entry is visible to fetch.
    assign lk_cnt = (train && (lk_idx == up_idx)) ? cnt_new : pht_q[lk_idx];

    always_comb begin
        pred_take_d = pred_take_q;
        if (flushD) begin
            pred_take_d = 1'b0;
        end else if (!stallD) begin
            pred_take_d = (state_q == ST_READY) & lk_cnt[1];
        end
    end

    assign sweep_idx_d = sweep_idx_q + PHT_IDX_W'(1);

    always_ff @(posedge clk) begin
        if (state_q == ST_INIT && !rst) begin
            pht_q[sweep_idx_q] <= 2'b01;
        end else if (train) begin
            pht_q[up_idx] <= cnt_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            sweep_idx_q <= '0;
            init_busy_q <= 1'b1;
            pred_take_q <= 1'b0;
        end else begin
            pred_take_q <= pred_take_d;
            case (state_q)
                ST_INIT: begin
                    sweep_idx_q <= sweep_idx_d;
                    if (sweep_idx_q == '1) begin
                        state_q     <= ST_READY;
                        init_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_READY;
                end
            endcase
        end
    end

    assign pred_takeD  = pred_take_q;
    assign init_busy   = init_busy_q;
    assign mispredictE = branchE & ~init_busy_q & (pred_takeE ^ actual_takeE);

    logic unused_pc_bits;
    assign unused_pc_bits = &{1'b0, pcF[31:PHT_IDX_W+2], pcF[1:0], pcE[31:PHT_IDX_W+2], pcE[1:0]};

endmodule

// File: tb/tb_branch_pht.sv
// Bench for branch_pht with a 16-entry table; gshare sequence runs when BHT_GSHARE_EN is defined.
module tb_branch_pht;

    logic        clk;
    logic        rst;
    logic [31:0] pcF;
    logic        stallD;
    logic        flushD;
    logic        pred_takeD;
    logic        branchE;
    logic        stallE;
    logic [31:0] pcE;
    logic        pred_takeE;
    logic        actual_takeE;
    logic        mispredictE;
    logic        init_busy;

    branch_pht #(.PHT_IDX_W(4), .GHR_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .pcF         (pcF),
        .stallD      (stallD),
        .flushD      (flushD),
        .pred_takeD  (pred_takeD),
        .branchE     (branchE),
        .stallE      (stallE),
        .pcE         (pcE),
        .pred_takeE  (pred_takeE),
        .actual_takeE(actual_takeE),
        .mispredictE (mispredictE),
        .init_busy   (init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pcf;
        logic        sd;
        logic        fd;
        logic        br;
        logic        se;
        logic [31:0] pce;
        logic        pe;
        logic        ae;
        logic        exp_mis;
        logic        exp_pd;
    } vec_t;

    localparam logic [31:0] PC_Z = 32'h0040_0000;  // index 0
    localparam logic [31:0] PC_A = 32'h0040_0010;  // index 4
    localparam logic [31:0] PC_B = 32'h0040_0020;  // index 8
    localparam logic [31:0] PC_C = 32'h0040_0030;  // index 12

    int   checks = 0;
    int   errors = 0;
    logic exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int n);
        pcF          = v.pcf;
        stallD       = v.sd;
        flushD       = v.fd;
        branchE      = v.br;
        stallE       = v.se;
        pcE          = v.pce;
        pred_takeE   = v.pe;
        actual_takeE = v.ae;
        #4;
        chk($sformatf("vec%0d_mispredictE", n), mispredictE, v.exp_mis);
        exp_q.push_back(v.exp_pd);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk($sformatf("vec%0d_queue", n), 0, 1);
        end else begin
            chk($sformatf("vec%0d_pred_takeD", n), pred_takeD, exp_q.pop_front());
        end
    endtask

    task automatic sweep_len(output int cnt, output logic pd_bad, output logic mis_bad);
        cnt     = 0;
        pd_bad  = 1'b0;
        mis_bad = 1'b0;
        while (init_busy === 1'b1 && cnt < 100) begin
            cnt++;
            pd_bad  = pd_bad | pred_takeD;
            mis_bad = mis_bad | mispredictE;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        stallD       = 1'b0;
        flushD       = 1'b0;
        branchE      = 1'b0;
        stallE       = 1'b0;
        pcE          = 32'h0;
        pred_takeE   = 1'b0;
        actual_takeE = 1'b0;
    endtask

    vec_t vecs [21];
    vec_t gv   [9];

    initial begin
        int   cnt;
        logic pd_bad;
        logic mis_bad;

        //          pcF   sd fd br se pcE   pe ae mis pd
        vecs[0]  = '{PC_C, 0, 0, 0, 0, PC_Z, 0, 0, 0, 0};
        vecs[1]  = '{PC_Z, 0, 0, 1, 0, PC_A, 0, 1, 1, 0};
        vecs[2]  = '{PC_Z, 0, 0, 1, 0, PC_A, 1, 1, 0, 0};
        vecs[3]  = '{PC_Z, 0, 0, 1, 0, PC_A, 1, 1, 0, 0};
        vecs[4]  = '{PC_A, 0, 0, 0, 0, PC_A, 0, 1, 0, 1};
        vecs[5]  = '{PC_A, 0, 0, 1, 0, PC_A, 1, 0, 1, 1};
        vecs[6]  = '{PC_A, 0, 0, 1, 0, PC_A, 1, 0, 1, 0};
        vecs[7]  = '{PC_A, 0, 0, 0, 0, PC_Z, 0, 0, 0, 0};
        vecs[8]  = '{PC_C, 0, 0, 1, 1, PC_C, 0, 1, 1, 0};
        vecs[9]  = '{PC_C, 0, 0, 1, 1, PC_C, 0, 1, 1, 0};
        vecs[10] = '{PC_C, 0, 0, 1, 1, PC_C, 0, 1, 1, 0};
        vecs[11] = '{PC_C, 0, 0, 1, 1, PC_C, 0, 1, 1, 0};
        vecs[12] = '{PC_C, 0, 0, 1, 0, PC_C, 0, 1, 1, 1};
        vecs[13] = '{PC_C, 0, 0, 0, 0, PC_Z, 0, 0, 0, 1};
        vecs[14] = '{PC_C, 0, 0, 1, 0, PC_C, 1, 0, 1, 0};
        vecs[15] = '{PC_B, 0, 0, 1, 0, PC_B, 0, 1, 1, 1};
        vecs[16] = '{PC_Z, 1, 0, 0, 0, PC_Z, 0, 0, 0, 1};
        vecs[17] = '{PC_B, 1, 1, 0, 0, PC_Z, 0, 0, 0, 0};
        vecs[18] = '{PC_B, 0, 0, 0, 0, PC_Z, 0, 0, 0, 1};
        vecs[19] = '{PC_B, 0, 1, 0, 0, PC_Z, 0, 0, 0, 0};
        vecs[20] = '{PC_B, 1, 0, 0, 0, PC_Z, 0, 0, 0, 0};

        // Four taken updates at PC 0 walk the GHR 0->1->3->7->F, training entries 0,1,3,7.
        gv[0] = '{PC_Z, 1, 0, 1, 0, 32'h0, 1, 1, 0, 0};
        gv[1] = '{PC_Z, 1, 0, 1, 0, 32'h0, 1, 1, 0, 0};
        gv[2] = '{PC_Z, 1, 0, 1, 0, 32'h0, 1, 1, 0, 0};
        gv[3] = '{PC_Z, 1, 0, 1, 0, 32'h0, 1, 1, 0, 0};
        gv[4] = '{PC_Z, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0};
        gv[5] = '{PC_Z, 0, 0, 1, 0, 32'h0, 0, 1, 1, 1};
        gv[6] = '{32'h0000_003C, 0, 0, 0, 0, 32'h0, 0, 0, 0, 1};
        gv[7] = '{PC_Z, 0, 0, 0, 0, 32'h0, 0, 0, 0, 1};
        gv[8] = '{32'h0000_0004, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0};

        rst = 1'b1;
        pcF = PC_Z;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_init_busy", init_busy, 1);
        chk("reset_pred_takeD", pred_takeD, 0);
        rst = 1'b0;

        // A taken branch presented throughout the sweep must neither train nor flag.
        pcF          = PC_C;
        branchE      = 1'b1;
        pcE          = PC_C;
        pred_takeE   = 1'b0;
        actual_takeE = 1'b1;
        sweep_len(cnt, pd_bad, mis_bad);
        idle_inputs();
        chk("sweep_length", cnt, 16);
        chk("sweep_pred_takeD_zero", pd_bad, 0);
        chk("sweep_mispredictE_zero", mis_bad, 0);

`ifndef BHT_GSHARE_EN
        for (int i = 0; i < 21; i++) begin
            apply(vecs[i], i);
        end
`else
        for (int i = 0; i < 9; i++) begin
            apply(gv[i], 100 + i);
        end
`endif
        idle_inputs();

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("midsweep_busy_before", init_busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midsweep_reset_pred", pred_takeD, 0);
        pcF = PC_B;
        sweep_len(cnt, pd_bad, mis_bad);
        chk("midsweep_length", cnt, 16);
        chk("midsweep_pred_takeD_zero", pd_bad, 0);
        @(posedge clk);
        #1;
        chk("post_sweep_lookup", pred_takeD, 0);
        chk("post_sweep_ready", init_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
